ram_4x16_ctrl: RTL and testbench
================================

RAM_4X16_CTRL -- requirements
Module: ram_4x16_ctrl

Interface
REQ-001 SHALL have ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- req  in  1  host request; sampled only in IDLE.
- op  in  2  command: 00 WRITE, 01 READ, 10 FILL, 11 SUM.
- addr  in  2  target word for WRITE/READ.
- wdata  in  16  write data (WRITE) or fill seed (FILL).
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- rdata  out  16  last word captured from memory.
- sum  out  18  SUM result.
- mem_rw  out  1  to RAM rw: 1 write, 0 read.
- mem_addr  out  2  to RAM addr.
- mem_din  out  16  to RAM data_in.
- mem_dout  in  16  from RAM data_out.

REQ-002 SHALL drive the 4-word x 16-bit RAM port as initiator. The RAM writes mem_din at mem_addr on the clk rising edge when mem_rw=1. The RAM presents the word at mem_addr combinationally on mem_dout when mem_rw=0.

Function
REQ-003 SHALL implement the states IDLE, WR, RD, FILL, SUM, DONE.
REQ-004 IDLE behaviour:
- busy=0, mem_rw=0.
- req=1 at a rising edge latches op, addr and wdata and moves to WR, RD, FILL or SUM per op.
- req while not in IDLE is ignored; no queueing.
REQ-005 busy SHALL be 1 in every state other than IDLE, including DONE.
REQ-006 WR:
- one cycle with mem_rw=1, mem_addr=latched addr, mem_din=latched wdata; then DONE.
- Latency: req sampled at edge k, RAM write at edge k+1, done high in cycle after edge k+2... precisely, done high between edges k+2 and k+3.
REQ-007 RD:
- one cycle with mem_rw=0, mem_addr=latched addr.
- rdata<=mem_dout at the exiting edge; then DONE.
- rdata is valid when done=1.
REQ-008 FILL:
- four consecutive write cycles, mem_addr 0,1,2,3, mem_din = seed+i modulo 2^16 (i=0..3); then DONE.
- Wrap-around: seed 16'hFFFE writes FFFE, FFFF, 0000, 0001.
REQ-009 SUM:
- sum clears to 0 on entry.
- four consecutive read cycles, mem_addr 0..3, mem_rw=0.
- each exiting edge: sum<=sum+zero-extended mem_dout; rdata<=mem_dout.
- 18-bit sum never overflows (max 4x65535 = 262140).
- then DONE.
REQ-010 DONE SHALL last exactly one cycle with done=1, then return to IDLE. A req in the DONE cycle is ignored.
REQ-011 mem_rw SHALL be 1 only in WR and FILL cycles. mem_rw, mem_addr and mem_din SHALL be registered (glitch-free).
REQ-012 rdata SHALL hold until the next READ or SUM. sum SHALL hold until the next SUM.
REQ-013 Command latencies in cycles from accepting edge to done pulse: WRITE 2, READ 2, FILL 5, SUM 5.

Reset
REQ-014 clr=0 SHALL asynchronously force:
- state IDLE
- busy=0, done=0, rdata=0, sum=0
- mem_rw=0, mem_addr=0, mem_din=0
REQ-015 Reset mid-command SHALL abort it:
- FILL: words not yet written stay unwritten; mem_rw drops immediately, not at the next edge.
- no done pulse for the aborted command.
REQ-016 After clr deasserts, the first req SHALL be accepted at the next rising edge.

Verification
REQ-017 Reset: clr=0 with req=1 -> all outputs 0, no RAM write; release, idle -> busy=0.
REQ-018 WRITE addr=2, wdata=16'hA5C3, then READ addr=2 -> rdata=A5C3 with done; each done exactly 2 cycles after accept.
REQ-019 FILL seed=16'hFFFE, then READ addr 0..3 -> FFFE, FFFF, 0000, 0001; FILL done 5 cycles after accept.
REQ-020 WRITE FFFF to all 4 addresses, then SUM -> sum=18'h3FFFC, rdata=FFFF, done 5 cycles after accept.
REQ-021 req held high through a WRITE -> exactly one command executes; a second command is accepted only after returning to IDLE.
REQ-022 FILL seed=16'h0010 on zeroed RAM, clr=0 two cycles after accept:
- addr0=0010, addr1=0011 written; addr2 and addr3 remain 0000.
- mem_rw=0 immediately; no done pulse.

Source files
------------

// File: rtl/ram_4x16_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_4x16_ctrl
// Description : Command sequencer for a 4-word x 16-bit RAM (write, read,
//               fill with incrementing seed, sum of all words).
// Revision    : 1.0 - initial release
// ============================================================================
module ram_4x16_ctrl (
    input  logic        clk,
    input  logic        clr,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [1:0]  addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic [17:0] sum,
    output logic        mem_rw,
    output logic [1:0]  mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_FILL = 3'd3;
    localparam logic [2:0] S_SUM  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [1:0] C_OP_WRITE = 2'b00;
    localparam logic [1:0] C_OP_READ  = 2'b01;
    localparam logic [1:0] C_OP_FILL  = 2'b10;
    localparam logic [1:0] C_OP_SUM   = 2'b11;
    localparam logic [1:0] C_LAST_WORD = 2'd3;

    logic [2:0]  r_state;
    logic        r_tail;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_rdata;
    logic [17:0] r_sum;
    logic        r_mem_rw;
    logic [1:0]  r_mem_addr;
    logic [15:0] r_mem_din;

    // Every command ends with one quiet "tail" cycle (memory idle) before
    // DONE, so done rises two edges after the last memory access edge minus one.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state    <= S_IDLE;
            r_tail     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rdata    <= 16'd0;
            r_sum      <= 18'd0;
            r_mem_rw   <= 1'b0;
            r_mem_addr <= 2'd0;
            r_mem_din  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_busy <= 1'b1;
                        r_tail <= 1'b0;
                        case (op)
                            C_OP_WRITE: begin
                                r_state    <= S_WR;
                                r_mem_rw   <= 1'b1;
                                r_mem_addr <= addr;
                                r_mem_din  <= wdata;
                            end
                            C_OP_READ: begin
                                r_state    <= S_RD;
                                r_mem_rw   <= 1'b0;
                                r_mem_addr <= addr;
                            end
                            C_OP_FILL: begin
                                r_state    <= S_FILL;
                                r_mem_rw   <= 1'b1;
                                r_mem_addr <= 2'd0;
                                r_mem_din  <= wdata;
                            end
                            C_OP_SUM: begin
                                r_state    <= S_SUM;
                                r_mem_rw   <= 1'b0;
                                r_mem_addr <= 2'd0;
                                r_sum      <= 18'd0;
                            end
                        endcase
                    end
                end
                S_WR: begin
                    if (!r_tail) begin
                        r_mem_rw <= 1'b0;
                        r_tail   <= 1'b1;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_tail  <= 1'b0;
                    end
                end
                S_RD: begin
                    if (!r_tail) begin
                        r_rdata <= mem_dout;
                        r_tail  <= 1'b1;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_tail  <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (!r_tail) begin
                        if (r_mem_addr == C_LAST_WORD) begin
                            r_mem_rw <= 1'b0;
                            r_tail   <= 1'b1;
                        end else begin
                            r_mem_addr <= r_mem_addr + 2'd1;
                            r_mem_din  <= r_mem_din + 16'd1;
                        end
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_tail  <= 1'b0;
                    end
                end
                S_SUM: begin
                    if (!r_tail) begin
                        r_sum   <= r_sum + {2'b00, mem_dout};
                        r_rdata <= mem_dout;
                        if (r_mem_addr == C_LAST_WORD) begin
                            r_tail <= 1'b1;
                        end else begin
                            r_mem_addr <= r_mem_addr + 2'd1;
                        end
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_tail  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_tail   <= 1'b0;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_mem_rw <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign sum      = r_sum;
    assign mem_rw   = r_mem_rw;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;

endmodule
`default_nettype wire

// File: tb/tb_ram_4x16_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_4x16_ctrl
// Description : Self-checking bench for ram_4x16_ctrl with an attached RAM
//               model and a command-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_4x16_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] wdata = 16'd0;
    logic        busy, done, mem_rw;
    logic [15:0] rdata, mem_din, mem_dout;
    logic [17:0] sum;
    logic [1:0]  mem_addr;

    logic [15:0] ram [4];
    logic [15:0] m_ram [4];
    logic [15:0] m_rdata = 16'd0;
    logic [17:0] m_sum = 18'd0;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    ram_4x16_ctrl dut (
        .clk(clk), .clr(clr), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .sum(sum),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    assign mem_dout = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_rw) begin
            ram[mem_addr] <= mem_din;
            wr_cnt <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < 4; i++) check(tag, {16'd0, ram[i]}, {16'd0, m_ram[i]});
    endtask

    // Issue one command, measure accept-to-done latency, then compare results
    // against the reference model. With hold=1, req stays high through the
    // command and wdata is corrupted after acceptance.
    task automatic run_cmd(input logic [1:0] c_op, input logic [1:0] c_addr,
                           input logic [15:0] c_data, input bit hold);
        int lat;
        int exp_lat;
        int exp_wr;
        int wr0;
        wr0 = wr_cnt;
        @(negedge clk);
        req = 1'b1; op = c_op; addr = c_addr; wdata = c_data;
        @(posedge clk);
        @(negedge clk);
        if (hold) wdata = ~c_data;
        else req = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        case (c_op)
            2'b00: begin m_ram[c_addr] = c_data; exp_lat = 2; exp_wr = 1; end
            2'b01: begin m_rdata = m_ram[c_addr]; exp_lat = 2; exp_wr = 0; end
            2'b10: begin
                for (int i = 0; i < 4; i++) m_ram[i] = c_data + 16'(i);
                exp_lat = 5; exp_wr = 4;
            end
            default: begin
                m_sum = 18'd0;
                for (int i = 0; i < 4; i++) m_sum = m_sum + 18'(m_ram[i]);
                m_rdata = m_ram[3];
                exp_lat = 5; exp_wr = 0;
            end
        endcase
        check("done_latency", lat, exp_lat);
        check("busy_in_done", {31'd0, busy}, 32'd1);
        check("rdata", {16'd0, rdata}, {16'd0, m_rdata});
        check("sum", {14'd0, sum}, {14'd0, m_sum});
        @(negedge clk);
        req = 1'b0;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("write_count", wr_cnt - wr0, exp_wr);
        if (hold) begin
            @(negedge clk);
            check("hold_no_reaccept", {31'd0, busy}, 32'd0);
            check("hold_write_count", wr_cnt - wr0, exp_wr);
        end
        check_ram("ram_contents");
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 4; i++) begin ram[i] = 16'd0; m_ram[i] = 16'd0; end

        // Reset held with an active request: nothing may happen.
        clr = 1'b0; req = 1'b1; op = 2'b00; addr = 2'd1; wdata = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_sum", {14'd0, sum}, 32'd0);
        check("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
        check("rst_mem_addr", {30'd0, mem_addr}, 32'd0);
        check("rst_mem_din", {16'd0, mem_din}, 32'd0);
        check("rst_no_write", wr_cnt, 0);
        req = 1'b0; clr = 1'b1;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        run_cmd(2'b00, 2'd2, 16'hA5C3, 1'b0);
        run_cmd(2'b01, 2'd2, 16'h0000, 1'b0);
        check("read_a5c3", {16'd0, rdata}, 32'h0000A5C3);

        run_cmd(2'b10, 2'd0, 16'hFFFE, 1'b0);
        for (int i = 0; i < 4; i++) run_cmd(2'b01, 2'(i), 16'h0000, 1'b0);

        for (int i = 0; i < 4; i++) run_cmd(2'b00, 2'(i), 16'hFFFF, 1'b0);
        run_cmd(2'b11, 2'd0, 16'h0000, 1'b0);
        check("sum_max", {14'd0, sum}, 32'h0003FFFC);

        run_cmd(2'b00, 2'd1, 16'h5A5A, 1'b1);
        run_cmd(2'b01, 2'd1, 16'h0000, 1'b0);

        for (int n = 0; n < 40; n++)
            run_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom), 1'b0);

        // Abort a FILL after two words have been written.
        for (int i = 0; i < 4; i++) run_cmd(2'b00, 2'(i), 16'h0000, 1'b0);
        d0 = done_cnt;
        @(negedge clk);
        req = 1'b1; op = 2'b10; wdata = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 clr = 1'b0;
        #1;
        check("abort_mem_rw", {31'd0, mem_rw}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        m_ram[0] = 16'h0010; m_ram[1] = 16'h0011;
        m_rdata = 16'd0; m_sum = 18'd0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check_ram("abort_ram");
        check("abort_rdata", {16'd0, rdata}, 32'd0);
        run_cmd(2'b01, 2'd1, 16'h0000, 1'b0);
        run_cmd(2'b01, 2'd2, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
